// File: rtl/rgb_led_pwm.sv
// rgb_led_pwm: 8-bit per-channel PWM driver for the active-low RGB LED.
//
// Colour commands are taken one at a time over a valid/ready port into a
// one-entry buffer. The buffer is only consumed at a PWM period boundary, so
// the displayed duty never changes mid-period. With FADE_PERIODS > 0 each
// channel walks 1 LSB toward the target once every FADE_PERIODS periods.
//
// Ports:
//   clk_25m       25 MHz system clock
//   rst_n         asynchronous active-low reset
//   cfg_valid     colour command valid
//   cfg_ready     command buffer free (transfer on cfg_valid & cfg_ready)
//   cfg_rgb       {R[23:16], G[15:8], B[7:0]} target duty
//   period_start  one-cycle pulse on the first cycle of each PWM period
//   busy          command pending or displayed duty differs from target
//   led_r/g/b     LED drives, active low (0 = lit)
module rgb_led_pwm #(
  parameter int unsigned PRESCALE     = 98,
  parameter int unsigned FADE_PERIODS = 4
) (
  input  logic        clk_25m,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [23:0] cfg_rgb,
  output logic        period_start,
  output logic        busy,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b
);

  localparam int unsigned PreW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned FadeW = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
  localparam logic [PreW-1:0]  PreLast  = PreW'(PRESCALE - 1);
  localparam logic [FadeW-1:0] FadeLast = FadeW'((FADE_PERIODS > 0) ? FADE_PERIODS - 1 : 0);

  logic [PreW-1:0]  pre_cnt_q, pre_cnt_d;
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic [FadeW-1:0] fade_cnt_q, fade_cnt_d;
  logic [23:0]      pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic [23:0]      tgt_q, tgt_d;
  logic [23:0]      cur_q, cur_d;
  logic [2:0]       led_q, led_d;
  logic             period_start_q, period_start_d;

  logic        tick;
  logic        boundary;
  logic        xfer;
  logic [23:0] cur_stepped;

  // Counters and compare.
  always_comb begin
    tick      = (pre_cnt_q == PreLast);
    boundary  = tick && (pwm_cnt_q == 8'hFF);
    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
    pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    // Registered so the pulse lands on the cycle where both counters read 0.
    period_start_d = boundary;
    led_d = 3'b111;
    for (int ch = 0; ch < 3; ch++) begin
      led_d[ch] = ~(pwm_cnt_q < cur_q[8*ch +: 8]);
    end
  end

  // One LSB toward the (pre-update) target per channel; never wraps since the
  // step only happens when the channel differs from its target.
  always_comb begin
    cur_stepped = cur_q;
    for (int ch = 0; ch < 3; ch++) begin
      if (cur_q[8*ch +: 8] < tgt_q[8*ch +: 8]) begin
        cur_stepped[8*ch +: 8] = cur_q[8*ch +: 8] + 8'd1;
      end else if (cur_q[8*ch +: 8] > tgt_q[8*ch +: 8]) begin
        cur_stepped[8*ch +: 8] = cur_q[8*ch +: 8] - 8'd1;
      end
    end
  end

  // Command buffer, target and displayed duty.
  always_comb begin
    xfer       = cfg_valid && !pend_v_q;
    pend_d     = pend_q;
    pend_v_d   = pend_v_q;
    tgt_d      = tgt_q;
    cur_d      = cur_q;
    fade_cnt_d = fade_cnt_q;

    if (boundary) begin
      if (FADE_PERIODS == 0) begin
        if (pend_v_q) begin
          tgt_d    = pend_q;
          cur_d    = pend_q;
          pend_v_d = 1'b0;
        end else begin
          cur_d = tgt_q;
        end
      end else if (fade_cnt_q == FadeLast) begin
        fade_cnt_d = '0;
        cur_d      = cur_stepped;
        if (pend_v_q) begin
          tgt_d    = pend_q;
          pend_v_d = 1'b0;
        end
      end else begin
        fade_cnt_d = fade_cnt_q + 1'b1;
      end
    end

    // A transfer needs pend_v_q = 0, so it never collides with consumption;
    // a command landing on a boundary cycle waits for the next boundary.
    if (xfer) begin
      pend_d   = cfg_rgb;
      pend_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      fade_cnt_q     <= '0;
      pend_q         <= '0;
      pend_v_q       <= 1'b0;
      tgt_q          <= '0;
      cur_q          <= '0;
      led_q          <= 3'b111;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      fade_cnt_q     <= fade_cnt_d;
      pend_q         <= pend_d;
      pend_v_q       <= pend_v_d;
      tgt_q          <= tgt_d;
      cur_q          <= cur_d;
      led_q          <= led_d;
      period_start_q <= period_start_d;
    end
  end

  assign cfg_ready    = ~pend_v_q;
  assign busy         = pend_v_q | (cur_q != tgt_q);
  assign period_start = period_start_q;
  assign led_r        = led_q[2];
  assign led_g        = led_q[1];
  assign led_b        = led_q[0];

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Testbench for rgb_led_pwm: three instances (PRESCALE = 2, FADE_PERIODS = 0,
// 1 and 3) are checked every cycle against a period-level behavioural model,
// plus directed scenarios with hand-computed expectations.
module tb_rgb_led_pwm;

  localparam int Pre    = 2;
  localparam int Period = Pre * 256;
  localparam int NInst  = 3;
  localparam int Lim    = 6000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld [NInst];
  logic [23:0] rgb [NInst];
  logic        rdy [NInst];
  logic        ps  [NInst];
  logic        bsy [NInst];
  logic        lr  [NInst];
  logic        lg  [NInst];
  logic        lb  [NInst];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NInst; g++) begin : g_dut
    rgb_led_pwm #(
      .PRESCALE    (Pre),
      .FADE_PERIODS((g == 0) ? 0 : (g == 1) ? 1 : 3)
    ) u_dut (
      .clk_25m     (clk),
      .rst_n       (rst_n),
      .cfg_valid   (vld[g]),
      .cfg_ready   (rdy[g]),
      .cfg_rgb     (rgb[g]),
      .period_start(ps[g]),
      .busy        (bsy[g]),
      .led_r       (lr[g]),
      .led_g       (lg[g]),
      .led_b       (lb[g])
    );
  end

  function automatic int fp_of(input int i);
    case (i)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        pv;
    logic [23:0] pend;
    logic [23:0] tgt;
    logic [23:0] cur;
    logic [2:0]  led;
    int          fcnt;
  } mstate_t;

  mstate_t m [NInst];
  int      k;  // cycles elapsed since reset release

  function automatic mstate_t model_reset();
    mstate_t r;
    r.pv = 1'b0; r.pend = '0; r.tgt = '0; r.cur = '0; r.led = 3'b111; r.fcnt = 0;
    return r;
  endfunction

  // State after the clock edge that ends cycle kk.
  function automatic mstate_t model_step(input mstate_t s, input int fp, input int kk,
                                         input logic v, input logic [23:0] c);
    mstate_t n;
    int pos;
    int pwm;
    n   = s;
    pos = kk % Period;
    pwm = pos / Pre;
    for (int ch = 0; ch < 3; ch++) begin
      n.led[ch] = (pwm < int'(s.cur[8*ch +: 8])) ? 1'b0 : 1'b1;
    end
    if (pos == Period - 1) begin
      if (fp == 0) begin
        if (s.pv) begin n.tgt = s.pend; n.cur = s.pend; n.pv = 1'b0; end
        else n.cur = s.tgt;
      end else if (s.fcnt == fp - 1) begin
        n.fcnt = 0;
        for (int ch = 0; ch < 3; ch++) begin
          int cd;
          int td;
          cd = int'(s.cur[8*ch +: 8]);
          td = int'(s.tgt[8*ch +: 8]);
          if (cd < td) n.cur[8*ch +: 8] = 8'(cd + 1);
          else if (cd > td) n.cur[8*ch +: 8] = 8'(cd - 1);
        end
        if (s.pv) begin n.tgt = s.pend; n.pv = 1'b0; end
      end else begin
        n.fcnt = s.fcnt + 1;
      end
    end
    if (v && !s.pv) begin n.pend = c; n.pv = 1'b1; end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0;
      for (int i = 0; i < NInst; i++) m[i] <= model_reset();
    end else begin
      k <= k + 1;
      for (int i = 0; i < NInst; i++) m[i] <= model_step(m[i], fp_of(i), k, vld[i], rgb[i]);
    end
  end

  // Per-cycle compare of {led_r, led_g, led_b, cfg_ready, busy, period_start}.
  always @(negedge clk) begin
    for (int i = 0; i < NInst; i++) begin
      logic [5:0] exp_v;
      logic [5:0] got_v;
      exp_v = {m[i].led, !m[i].pv, (m[i].pv || (m[i].cur != m[i].tgt)),
               ((k > 0) && (k % Period == 0))};
      got_v = {lr[i], lg[i], lb[i], rdy[i], bsy[i], ps[i]};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL model_cmp inst%0d cyc%0d: got %b expected %b (rgb,rdy,busy,ps)",
                 i, k, got_v, exp_v);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input int got, input int exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
    end
  endtask

  task automatic send(input int i, input logic [23:0] c);
    int n;
    n = 0;
    @(negedge clk);
    vld[i] = 1'b1;
    rgb[i] = c;
    while (!rdy[i] && n < Lim) begin @(negedge clk); n++; end
    if (n >= Lim) chk("send_timeout", n, 0);
    @(negedge clk);
    vld[i] = 1'b0;
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    while (!rdy[i] && n < Lim) begin @(negedge clk); n++; end
    if (n >= Lim) chk("ready_timeout", n, 0);
  endtask

  // Samples Period cycles starting at the current negedge.
  task automatic measure(input int i, output int lo_r, output int lo_g, output int lo_b,
                         output int first_r);
    lo_r = 0; lo_g = 0; lo_b = 0; first_r = -1;
    for (int c = 0; c < Period; c++) begin
      if (c > 0) @(negedge clk);
      if (!lr[i]) begin lo_r++; if (first_r < 0) first_r = c; end
      if (!lg[i]) lo_g++;
      if (!lb[i]) lo_b++;
    end
  endtask

  task automatic count_fade(input int i, output int cnt);
    int n;
    n = 0; cnt = 0;
    while (bsy[i] && n < 8 * Period) begin
      @(negedge clk); n++;
      if (ps[i]) cnt++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, lo_r, lo_g, lo_b, first_r;
    for (int i = 0; i < NInst; i++) begin vld[i] = 1'b0; rgb[i] = '0; end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset_led_r", int'(lr[0]), 1);
    chk("reset_ready", int'(rdy[0]), 1);
    rst_n = 1'b1;
    chk("release_busy", int'(bsy[1]), 0);
    chk("release_leds", int'({lr[2], lg[2], lb[2]}), 7);

    // First period_start one full period after release.
    n = 0;
    while (!ps[0] && n < Lim) begin @(negedge clk); n++; end
    chk("first_period_start", n, 512);

    // Direct load.
    send(0, 24'h80_00_FF);
    wait_ready(0);
    chk("ready_rise_on_ps", int'(ps[0]), 1);
    measure(0, lo_r, lo_g, lo_b, first_r);
    chk("direct_r_low", lo_r, 256);
    chk("direct_g_low", lo_g, 0);
    chk("direct_b_low", lo_b, 510);
    chk("direct_r_first", first_r, 1);

    // Back-pressure: A accepted, B held until the boundary consuming A.
    send(0, 24'h10_20_30);
    chk("bp_ready_low", int'(rdy[0]), 0);
    vld[0] = 1'b1;
    rgb[0] = 24'h40_50_60;
    wait_ready(0);
    chk("bp_ready_at_boundary", int'(ps[0]), 1);
    @(negedge clk);
    vld[0] = 1'b0;
    n = 1;
    while (!rdy[0] && n < Lim) begin @(negedge clk); n++; end
    chk("bp_b_one_period", n, 512);

    // Fade up/down on FADE_PERIODS = 1.
    send(1, 24'h03_00_02);
    count_fade(1, cnt);
    chk("fade_up_boundaries", cnt, 4);
    chk("fade_up_ps", int'(ps[1]), 1);
    measure(1, lo_r, lo_g, lo_b, first_r);
    chk("fade_up_r_low", lo_r, 6);
    chk("fade_up_g_low", lo_g, 0);
    chk("fade_up_b_low", lo_b, 4);
    send(1, 24'h00_00_00);
    count_fade(1, cnt);
    chk("fade_down_boundaries", cnt, 4);

    // FADE_PERIODS = 3: steps spaced three boundaries apart.
    send(2, 24'h00_02_01);
    count_fade(2, cnt);
    chk("fade3_done", int'(bsy[2]), 0);

    // Long fade on inst1 to be interrupted by reset later.
    send(1, 24'hFF_FF_FF);

    // Extremes.
    send(0, 24'hFF_00_FF);
    wait_ready(0);
    measure(0, lo_r, lo_g, lo_b, first_r);
    chk("ext_r_high", Period - lo_r, 2);
    chk("ext_g_high", Period - lo_g, 512);
    chk("ext_b_high", Period - lo_b, 2);

    // Reset mid-fade with a command pending on inst0.
    send(0, 24'h10_20_30);
    chk("pre_reset_r_lit", int'(lr[0]), 0);
    chk("pre_reset_fading", int'(bsy[1]), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_r_off", int'(lr[0]), 1);
    chk("async_reset_b_off", int'(lb[0]), 1);
    chk("async_reset_busy", int'(bsy[1]), 0);
    chk("async_reset_ready", int'(rdy[0]), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (600) @(negedge clk);
    chk("post_reset_busy0", int'(bsy[0]), 0);
    chk("post_reset_busy1", int'(bsy[1]), 0);
    measure(0, lo_r, lo_g, lo_b, first_r);
    chk("no_stale_r", lo_r, 0);
    chk("no_stale_b", lo_b, 0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
